combo_lock_ctrl: RTL

COMBO_LOCK_CTRL -- requirements
Module: combo_lock_ctrl

---
 rtl/combo_lock_pkg.sv | 20 ++
 rtl/relock_timer.sv | 30 +++
 rtl/combo_lock_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/combo_lock_pkg.sv
// Shared types and default parameters for the combination lock controller.
package combo_lock_pkg;

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    OPEN     = 2'd1,
    NEW_CODE = 2'd2,
    ALARM    = 2'd3
  } lock_state_e;

  localparam int               DEF_CODE_LEN  = 4;
  localparam int               DEF_MAX_TRIES = 3;
  localparam logic [15:0]      DEF_CODE      = 16'h1234;

  // Only decimal digits may be committed; anything above 9 is switch noise.
  function automatic logic is_bcd(input logic [3:0] d);
    return (d <= 4'd9);
  endfunction

endpackage

// File: rtl/relock_timer.sv
// Down-counter that keeps the lock open for a fixed number of cycles.
module relock_timer #(
  parameter int CYCLES = 8,
  localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1
)(
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic done
);

  logic [W-1:0] count_r;

  // Load has priority over counting; the count parks at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= W'(CYCLES - 1);
    end else if (en && (count_r != {W{1'b0}})) begin
      count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign done = (count_r == {W{1'b0}});

endmodule

// File: rtl/combo_lock_ctrl.sv
// Combination lock controller: BCD code entry, timed auto-relock, code change
// and a latched alarm after repeated wrong codes.
module combo_lock_ctrl
  import combo_lock_pkg::*;
#(
  parameter int                    CODE_LEN     = DEF_CODE_LEN,
  parameter int                    MAX_TRIES    = DEF_MAX_TRIES,
  parameter int                    OPEN_CYCLES  = 250_000_000,
  parameter logic [CODE_LEN*4-1:0] DEFAULT_CODE = DEF_CODE
)(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit,
  input  logic       enter,
  input  logic       set_new,
  output logic       open,
  output logic       alarm,
  output logic       new_mode,
  output logic [2:0] digit_cnt,
  output logic [1:0] tries
);

  localparam int         CW         = CODE_LEN * 4;
  localparam logic [2:0] CNT_LAST   = 3'(CODE_LEN - 1);
  localparam logic [1:0] TRIES_LAST = 2'(MAX_TRIES - 1);

  lock_state_e    state_r;
  logic [CW-1:0]  entry_r;
  logic [CW-1:0]  code_r;
  logic [CW-1:0]  full_s;
  logic           valid_s;
  logic           last_s;
  logic           match_s;
  logic           timer_load_s;
  logic           timer_en_s;
  logic           timer_done_s;

  // The completing digit is compared without first landing in the buffer.
  assign full_s       = {entry_r[CW-5:0], digit};
  assign valid_s      = enter && is_bcd(digit);
  assign last_s       = (digit_cnt == CNT_LAST);
  assign match_s      = (full_s == code_r);
  assign timer_load_s = (state_r == LOCKED) && valid_s && last_s && match_s;
  assign timer_en_s   = (state_r == OPEN);

  relock_timer #(.CYCLES(OPEN_CYCLES)) u_relock_timer (
    .clk   (clk),
    .reset (reset),
    .load  (timer_load_s),
    .en    (timer_en_s),
    .done  (timer_done_s)
  );

  // Lock FSM with registered status outputs, entry buffer and stored code.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= LOCKED;
      open      <= 1'b0;
      alarm     <= 1'b0;
      new_mode  <= 1'b0;
      digit_cnt <= 3'd0;
      tries     <= 2'd0;
      entry_r   <= {CW{1'b0}};
      code_r    <= DEFAULT_CODE;
    end else begin
      case (state_r)
        LOCKED: begin
          if (valid_s && last_s) begin
            digit_cnt <= 3'd0;
            entry_r   <= {CW{1'b0}};
            if (match_s) begin
              state_r <= OPEN;
              open    <= 1'b1;
              tries   <= 2'd0;
            end else if (tries == TRIES_LAST) begin
              state_r <= ALARM;
              alarm   <= 1'b1;
              tries   <= 2'd0;
            end else begin
              tries   <= tries + 2'd1;
            end
          end else if (valid_s) begin
            entry_r   <= full_s;
            digit_cnt <= digit_cnt + 3'd1;
          end else begin
            state_r <= LOCKED;
          end
        end
        OPEN: begin
          if (set_new) begin
            state_r  <= NEW_CODE;
            open     <= 1'b0;
            new_mode <= 1'b1;
          end else if (valid_s || timer_done_s) begin
            state_r <= LOCKED;
            open    <= 1'b0;
          end else begin
            state_r <= OPEN;
          end
        end
        NEW_CODE: begin
          if (valid_s && last_s) begin
            code_r    <= full_s;
            state_r   <= LOCKED;
            new_mode  <= 1'b0;
            digit_cnt <= 3'd0;
            entry_r   <= {CW{1'b0}};
          end else if (valid_s) begin
            entry_r   <= full_s;
            digit_cnt <= digit_cnt + 3'd1;
          end else begin
            state_r <= NEW_CODE;
          end
        end
        ALARM: begin
          state_r <= ALARM;
        end
        default: begin
          state_r   <= LOCKED;
          open      <= 1'b0;
          alarm     <= 1'b0;
          new_mode  <= 1'b0;
          digit_cnt <= 3'd0;
          entry_r   <= {CW{1'b0}};
        end
      endcase
    end
  end

endmodule
